distributor_burst_arbiter: RTL and testbench
============================================

// Module: distributor_burst_arbiter
// PURPOSE
//  Shares one AXI4 master write channel (INCR bursts, ID 0) between N_REQ requesters feeding the Distributor's S00_AXI port.
//  Round-robin arbitration, one burst at a time; the grant is held from AW through B.
//  Each requester supplies address, length and a W-beat stream, and gets a done pulse carrying BRESP.
// PARAMETERS
//  N_REQ   4   number of requesters (2..8)
//  ADDR_W  32  AXI address width
//  DATA_W  32  AXI data width (AWSIZE = clog2(DATA_W/8), WSTRB all ones)
// PORTS
//  ACLK          in   1             clock
//  ARESETN       in   1             asynchronous active-low reset
//  req_valid     in   N_REQ         per-requester command valid
//  req_ready     out  N_REQ         one-hot command accept (1-cycle pulse)
//  req_addr      in   N_REQ*ADDR_W  burst start address, requester i at [i*ADDR_W+:ADDR_W]
//  req_len       in   N_REQ*8       AWLEN (beats-1), requester i at [i*8+:8]
//  req_wdata     in   N_REQ*DATA_W  W data, requester i slice
//  req_wvalid    in   N_REQ         W data valid
//  req_wready    out  N_REQ         W data accepted (only the granted bit may be 1)
//  req_done      out  N_REQ         one-hot 1-cycle pulse at burst completion
//  req_resp      out  2             response for the req_done pulse (BRESP or 2'b10)
//  m_axi_awaddr  out  ADDR_W ; m_axi_awlen out 8 ; m_axi_awsize out 3 ; m_axi_awburst out 2 (=2'b01)
//  m_axi_awvalid out  1 ; m_axi_awready in 1
//  m_axi_wdata   out  DATA_W ; m_axi_wstrb out DATA_W/8 ; m_axi_wlast out 1
//  m_axi_wvalid  out  1 ; m_axi_wready in 1
//  m_axi_bresp   in   2 ; m_axi_bvalid in 1 ; m_axi_bready out 1
// BEHAVIOUR
//  Reset (async assert, sync deassert): state=IDLE, rr_ptr=0, beat_cnt=0; all valid/ready/done outputs 0,
//   req_resp=0, awaddr/awlen=0. Reset mid-burst drops all handshakes immediately; no burst resumes.
//  FSM IDLE -> AW -> W -> B -> IDLE.
//  IDLE: if any req_valid, grant = first set bit at/after rr_ptr (wrapping); register addr/len,
//   pulse req_ready[grant]; rr_ptr <= grant+1 mod N_REQ. Next cycle enters AW with awvalid=1.
//  4KB check at grant: if addr[11:0] + (len+1)*(DATA_W/8) > 4096 -> no bus activity;
//   req_done[grant]=1, req_resp=2'b10 on the following cycle; back to IDLE.
//  AW: awvalid held until awready; awaddr/awlen stable while awvalid=1. On handshake -> W.
//  W: m_axi_wdata = granted slice; m_axi_wvalid = req_wvalid[grant];
//   req_wready[grant] = m_axi_wready (combinational pass-through, no buffering).
//   beat_cnt increments per W handshake; wlast=1 when beat_cnt==len. Handshake with wlast -> B.
//  B: bready=1; on bvalid: req_done[grant]=1 and req_resp=bresp for that cycle only (registered,
//   visible the cycle after the handshake); -> IDLE. Latency from B handshake to new AW >= 2 cycles.
//  W is never issued before the AW handshake; at most one outstanding burst; no AW/W overlap.
//  Non-granted requesters: req_ready/req_wready/req_done bits always 0.
//  Simultaneous requests: pure round-robin; a requester that keeps req_valid high cannot starve others.
//  req_valid dropping after grant is ignored (command already captured).
//  len=0: single beat, wlast on the first beat.
// TESTING
//  1. Req0 addr=0x0 len=7 data 1..8, AXI VIP slave memory -> 8 beats, wlast on beat 8, read-back 1..8, req_done[0], resp=0.
//  2. All 4 req_valid held, len=0 each -> grants in order 0,1,2,3,0; no requester granted twice before all others.
//  3. Req2 addr=0xFF8 len=3 (DATA_W=32) -> no AWVALID, req_done[2] with req_resp=2'b10; addr=0xFF0 len=3 is accepted.
//  4. Slave backpressure: awready delayed 5 cycles, random wready/req_wvalid gaps -> data order and count intact, AW stable.
//  5. Slave returns bresp=2'b10 -> req_resp=2'b10 on req_done; next grant proceeds normally.
//  6. ARESETN low mid-W (beat 3 of 8) -> all valids drop same cycle; after release rr_ptr=0, fresh burst completes cleanly.

Source files
------------

// File: rtl/distributor_burst_arbiter.sv
// Round-robin arbiter sharing one AXI4 write channel (INCR, ID 0) between N_REQ requesters.
// One burst in flight at a time; the grant is held from AW through B.
`timescale 1ns/1ps

module distributor_burst_arbiter #(
    parameter int unsigned N_REQ  = 4,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic                    ACLK,
    input  logic                    ARESETN,
    input  logic [N_REQ-1:0]        req_valid,
    output logic [N_REQ-1:0]        req_ready,
    input  logic [N_REQ*ADDR_W-1:0] req_addr,
    input  logic [N_REQ*8-1:0]      req_len,
    input  logic [N_REQ*DATA_W-1:0] req_wdata,
    input  logic [N_REQ-1:0]        req_wvalid,
    output logic [N_REQ-1:0]        req_wready,
    output logic [N_REQ-1:0]        req_done,
    output logic [1:0]              req_resp,
    output logic [ADDR_W-1:0]       m_axi_awaddr,
    output logic [7:0]              m_axi_awlen,
    output logic [2:0]              m_axi_awsize,
    output logic [1:0]              m_axi_awburst,
    output logic                    m_axi_awvalid,
    input  logic                    m_axi_awready,
    output logic [DATA_W-1:0]       m_axi_wdata,
    output logic [DATA_W/8-1:0]     m_axi_wstrb,
    output logic                    m_axi_wlast,
    output logic                    m_axi_wvalid,
    input  logic                    m_axi_wready,
    input  logic [1:0]              m_axi_bresp,
    input  logic                    m_axi_bvalid,
    output logic                    m_axi_bready
);

    localparam int unsigned IDX_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned STRB_W = DATA_W / 8;
    localparam logic [2:0]  AW_SIZE = 3'($clog2(STRB_W));

    typedef enum logic [2:0] {StIdle, StAw, StW, StB, StErr} state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]   grant_q, grant_d;
    logic [7:0]         beat_cnt_q, beat_cnt_d;
    logic [ADDR_W-1:0]  awaddr_q, awaddr_d;
    logic [7:0]         awlen_q, awlen_d;
    logic [N_REQ-1:0]   req_ready_q, req_ready_d;
    logic [N_REQ-1:0]   req_done_q, req_done_d;
    logic [1:0]         req_resp_q, req_resp_d;

    logic               arb_vld;
    logic [IDX_W-1:0]   arb_idx;
    logic [IDX_W-1:0]   rr_next;
    logic [ADDR_W-1:0]  sel_addr;
    logic [7:0]         sel_len;
    logic [31:0]        burst_end;
    logic               cross_4k;
    logic               w_hs;

    // First requesting index at or after rr_ptr, wrapping around.
    always_comb begin
        arb_vld = 1'b0;
        arb_idx = rr_ptr_q;
        for (int i = 0; i < int'(N_REQ); i++) begin
            if (!arb_vld && req_valid[(int'(rr_ptr_q) + i) % int'(N_REQ)]) begin
                arb_vld = 1'b1;
                arb_idx = IDX_W'((int'(rr_ptr_q) + i) % int'(N_REQ));
            end
        end
    end

    assign rr_next   = (int'(arb_idx) == int'(N_REQ) - 1) ? '0 : arb_idx + 1'b1;
    assign sel_addr  = req_addr[int'(arb_idx)*int'(ADDR_W) +: ADDR_W];
    assign sel_len   = req_len[int'(arb_idx)*8 +: 8];
    assign burst_end = 32'(sel_addr[11:0]) + (32'(sel_len) + 32'd1) * STRB_W;
    assign cross_4k  = burst_end > 32'd4096;

    assign w_hs = (state_q == StW) && m_axi_wvalid && m_axi_wready;

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        grant_d     = grant_q;
        beat_cnt_d  = beat_cnt_q;
        awaddr_d    = awaddr_q;
        awlen_d     = awlen_q;
        req_ready_d = '0;
        req_done_d  = '0;
        req_resp_d  = 2'b00;
        case (state_q)
            StIdle: begin
                if (arb_vld) begin
                    grant_d              = arb_idx;
                    rr_ptr_d             = rr_next;
                    req_ready_d[arb_idx] = 1'b1;
                    if (cross_4k) begin
                        // Rejected locally: never reaches the bus.
                        req_done_d[arb_idx] = 1'b1;
                        req_resp_d          = 2'b10;
                        state_d             = StErr;
                    end else begin
                        awaddr_d   = sel_addr;
                        awlen_d    = sel_len;
                        beat_cnt_d = '0;
                        state_d    = StAw;
                    end
                end
            end
            StAw: begin
                if (m_axi_awready) state_d = StW;
            end
            StW: begin
                if (w_hs) begin
                    if (beat_cnt_q == awlen_q) begin
                        beat_cnt_d = '0;
                        state_d    = StB;
                    end else begin
                        beat_cnt_d = beat_cnt_q + 8'd1;
                    end
                end
            end
            StB: begin
                if (m_axi_bvalid) begin
                    req_done_d[grant_q] = 1'b1;
                    req_resp_d          = m_axi_bresp;
                    state_d             = StIdle;
                end
            end
            // One-cycle holdoff so the rejected requester can drop req_valid.
            StErr:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q     <= StIdle;
            rr_ptr_q    <= '0;
            grant_q     <= '0;
            beat_cnt_q  <= '0;
            awaddr_q    <= '0;
            awlen_q     <= '0;
            req_ready_q <= '0;
            req_done_q  <= '0;
            req_resp_q  <= 2'b00;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_q     <= grant_d;
            beat_cnt_q  <= beat_cnt_d;
            awaddr_q    <= awaddr_d;
            awlen_q     <= awlen_d;
            req_ready_q <= req_ready_d;
            req_done_q  <= req_done_d;
            req_resp_q  <= req_resp_d;
        end
    end

    // W path is a straight pass-through of the granted requester.
    always_comb begin
        req_wready = '0;
        if (state_q == StW) req_wready[grant_q] = m_axi_wready;
    end

    assign req_ready     = req_ready_q;
    assign req_done      = req_done_q;
    assign req_resp      = req_resp_q;
    assign m_axi_awaddr  = awaddr_q;
    assign m_axi_awlen   = awlen_q;
    assign m_axi_awsize  = AW_SIZE;
    assign m_axi_awburst = 2'b01;
    assign m_axi_awvalid = (state_q == StAw);
    assign m_axi_wdata   = req_wdata[int'(grant_q)*int'(DATA_W) +: DATA_W];
    assign m_axi_wstrb   = '1;
    assign m_axi_wvalid  = (state_q == StW) && req_wvalid[grant_q];
    assign m_axi_wlast   = (state_q == StW) && (beat_cnt_q == awlen_q);
    assign m_axi_bready  = (state_q == StB);

endmodule

// File: tb/tb_distributor_burst_arbiter.sv
// Scoreboard bench for distributor_burst_arbiter: directed bursts against a simple AXI slave model.
`timescale 1ns/1ps

module tb_distributor_burst_arbiter;

    localparam int N   = 4;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int LIM = 2000;

    logic ACLK = 1'b0;
    logic ARESETN = 1'b0;
    always #5 ACLK = ~ACLK;

    logic [N-1:0]    req_valid, req_ready, req_wvalid, req_wready, req_done;
    logic [N*AW-1:0] req_addr;
    logic [N*8-1:0]  req_len;
    logic [N*DW-1:0] req_wdata;
    logic [1:0]      req_resp;
    logic [AW-1:0]   m_axi_awaddr;
    logic [7:0]      m_axi_awlen;
    logic [2:0]      m_axi_awsize;
    logic [1:0]      m_axi_awburst;
    logic            m_axi_awvalid, m_axi_awready;
    logic [DW-1:0]   m_axi_wdata;
    logic [DW/8-1:0] m_axi_wstrb;
    logic            m_axi_wlast, m_axi_wvalid, m_axi_wready;
    logic [1:0]      m_axi_bresp;
    logic            m_axi_bvalid, m_axi_bready;

    distributor_burst_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_len(req_len),
        .req_wdata(req_wdata), .req_wvalid(req_wvalid), .req_wready(req_wready),
        .req_done(req_done), .req_resp(req_resp),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen), .m_axi_awsize(m_axi_awsize),
        .m_axi_awburst(m_axi_awburst), .m_axi_awvalid(m_axi_awvalid),
        .m_axi_awready(m_axi_awready), .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
        .m_axi_wlast(m_axi_wlast), .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready)
    );

    // Per-requester drive variables, packed onto the DUT vectors.
    logic        v_valid[N];
    logic [31:0] v_addr[N];
    logic [7:0]  v_len[N];
    logic [31:0] v_wdata[N];
    logic        v_wvalid[N];

    always_comb begin
        req_valid  = '0;
        req_wvalid = '0;
        req_addr   = '0;
        req_len    = '0;
        req_wdata  = '0;
        for (int i = 0; i < N; i++) begin
            req_valid[i]            = v_valid[i];
            req_wvalid[i]           = v_wvalid[i];
            req_addr[i*AW +: AW]    = v_addr[i];
            req_len[i*8 +: 8]       = v_len[i];
            req_wdata[i*DW +: DW]   = v_wdata[i];
        end
    end

    int passed = 0;
    int total  = 0;
    int w_hs_cnt = 0;
    bit abort = 1'b0;

    // Scoreboard queues filled by the stimulus side.
    int          exp_grant[$];
    logic [39:0] exp_aw[$];
    logic [32:0] exp_w[$];
    logic [5:0]  exp_done[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: actual=%0h expected=%0h", nm, act, exp);
    endtask

    task automatic unexp(input string nm, input logic [63:0] act);
        total++;
        $display("FAIL %s: actual=%0h expected=no event", nm, act);
    endtask

    function automatic logic [3:0] oh(input int r);
        logic [3:0] one;
        one = 4'b0001;
        return one << r;
    endfunction

    task automatic expect_burst(input int r, input logic [31:0] addr, input logic [7:0] len,
                                input logic [31:0] base, input logic [1:0] resp);
        exp_grant.push_back(r);
        exp_aw.push_back({addr, len});
        for (int b = 0; b <= int'(len); b++) exp_w.push_back({(b == int'(len)), base + 32'(b)});
        exp_done.push_back({oh(r), resp});
    endtask

    task automatic expect_reject(input int r);
        exp_grant.push_back(r);
        exp_done.push_back({oh(r), 2'b10});
    endtask

    // Requester model: issue one command, then stream nbeats W beats.
    task automatic drive_cmd(input int r, input logic [31:0] addr, input logic [7:0] len,
                             input logic [31:0] base, input int nbeats, input bit gaps,
                             input bit keep_valid);
        int t;
        v_addr[r]  = addr;
        v_len[r]   = len;
        v_valid[r] = 1'b1;
        t = 0;
        do begin @(negedge ACLK); t++; end while (!req_ready[r] && t < LIM && !abort);
        if (t >= LIM) unexp($sformatf("req%0d_ready_timeout", r), 64'(t));
        @(posedge ACLK); #1;
        if (!keep_valid || abort) v_valid[r] = 1'b0;
        for (int b = 0; b < nbeats && !abort; b++) begin
            if (gaps) begin
                v_wvalid[r] = 1'b0;
                repeat ($urandom_range(0, 2)) begin @(posedge ACLK); #1; end
            end
            v_wvalid[r] = 1'b1;
            v_wdata[r]  = base + 32'(b);
            t = 0;
            do begin @(negedge ACLK); t++; end while (!req_wready[r] && t < LIM && !abort);
            if (t >= LIM) unexp($sformatf("req%0d_wready_timeout", r), 64'(t));
            @(posedge ACLK); #1;
        end
        v_wvalid[r] = 1'b0;
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while ((exp_grant.size() + exp_aw.size() + exp_w.size() + exp_done.size()) != 0
               && t < LIM) begin
            @(negedge ACLK);
            t++;
        end
        if (t >= LIM)
            unexp("drain_timeout", 64'(exp_grant.size() + exp_aw.size() + exp_w.size() +
                                        exp_done.size()));
        repeat (3) @(negedge ACLK);
    endtask

    task automatic do_reset();
        @(posedge ACLK); #1;
        ARESETN = 1'b0;
        repeat (2) @(posedge ACLK);
        #1 ARESETN = 1'b1;
    endtask

    // AXI slave model with memory, configurable AW delay, W backpressure and BRESP.
    int          cfg_aw_delay = 0;
    bit          cfg_w_rand = 1'b0;
    logic [1:0]  cfg_bresp = 2'b00;
    logic [31:0] mem[logic [31:0]];

    initial begin
        bit s_av, s_aw_hs, s_w_hs, s_wl, s_b_hs;
        int aw_cnt;
        logic [31:0] wr_ptr;
        m_axi_awready = 1'b0;
        m_axi_wready  = 1'b0;
        m_axi_bvalid  = 1'b0;
        m_axi_bresp   = 2'b00;
        aw_cnt = 0;
        wr_ptr = '0;
        forever begin
            @(negedge ACLK);
            s_av    = m_axi_awvalid;
            s_aw_hs = m_axi_awvalid && m_axi_awready;
            s_w_hs  = m_axi_wvalid && m_axi_wready;
            s_wl    = m_axi_wlast;
            s_b_hs  = m_axi_bvalid && m_axi_bready;
            if (s_aw_hs) wr_ptr = m_axi_awaddr;
            if (s_w_hs) begin
                mem[wr_ptr] = m_axi_wdata;
                wr_ptr += 32'd4;
            end
            @(posedge ACLK); #1;
            if (!ARESETN) begin
                m_axi_awready = 1'b0;
                m_axi_wready  = 1'b0;
                m_axi_bvalid  = 1'b0;
                aw_cnt = 0;
            end else begin
                if (s_aw_hs) begin
                    m_axi_awready = 1'b0;
                    aw_cnt = 0;
                end else if (s_av && !m_axi_awready) begin
                    if (aw_cnt >= cfg_aw_delay) m_axi_awready = 1'b1;
                    else aw_cnt++;
                end
                m_axi_wready = cfg_w_rand ? 1'($urandom_range(0, 1)) : 1'b1;
                if (s_w_hs && s_wl) begin
                    m_axi_bvalid = 1'b1;
                    m_axi_bresp  = cfg_bresp;
                end else if (s_b_hs) begin
                    m_axi_bvalid = 1'b0;
                end
            end
        end
    end

    // Monitor: pops an expectation for every observed grant, AW, W beat and done pulse.
    initial begin
        bit          prev_stall;
        logic [39:0] prev_aw;
        int          g;
        logic [39:0] ea;
        logic [32:0] ew;
        logic [5:0]  ed;
        prev_stall = 1'b0;
        prev_aw    = '0;
        forever begin
            @(negedge ACLK);
            if (!ARESETN) begin
                prev_stall = 1'b0;
                continue;
            end
            if (req_ready != '0) begin
                if (exp_grant.size() == 0) unexp("grant", 64'(req_ready));
                else begin
                    g = exp_grant.pop_front();
                    chk("grant_onehot", 64'(req_ready), 64'(oh(g)));
                end
            end
            if (prev_stall) begin
                if (!m_axi_awvalid) unexp("awvalid_dropped", 64'(prev_aw));
                else chk("aw_stable", 64'({m_axi_awaddr, m_axi_awlen}), 64'(prev_aw));
            end
            prev_stall = m_axi_awvalid && !m_axi_awready;
            prev_aw    = {m_axi_awaddr, m_axi_awlen};
            if (m_axi_awvalid && m_axi_awready) begin
                if (exp_aw.size() == 0) unexp("aw", 64'({m_axi_awaddr, m_axi_awlen}));
                else begin
                    ea = exp_aw.pop_front();
                    chk("aw_addr_len", 64'({m_axi_awaddr, m_axi_awlen}), 64'(ea));
                    chk("aw_size_burst", 64'({m_axi_awsize, m_axi_awburst}), 64'({3'd2, 2'b01}));
                end
            end
            if (m_axi_wvalid && m_axi_wready) begin
                w_hs_cnt++;
                if (exp_w.size() == 0) unexp("w_beat", 64'({m_axi_wlast, m_axi_wdata}));
                else begin
                    ew = exp_w.pop_front();
                    chk("w_data_last", 64'({m_axi_wlast, m_axi_wdata}), 64'(ew));
                    chk("wstrb", 64'(m_axi_wstrb), 64'h0f);
                end
            end
            if (req_done != '0) begin
                if (exp_done.size() == 0) unexp("done", 64'({req_done, req_resp}));
                else begin
                    ed = exp_done.pop_front();
                    chk("done_resp", 64'({req_done, req_resp}), 64'(ed));
                end
            end
        end
    end

    initial begin
        int t;
        int start;
        for (int i = 0; i < N; i++) begin
            v_valid[i]  = 1'b0;
            v_wvalid[i] = 1'b0;
            v_addr[i]   = '0;
            v_len[i]    = '0;
            v_wdata[i]  = '0;
        end

        // Reset state
        repeat (3) @(posedge ACLK);
        @(negedge ACLK);
        chk("rst_awvalid", 64'(m_axi_awvalid), 64'd0);
        chk("rst_wvalid", 64'(m_axi_wvalid), 64'd0);
        chk("rst_bready", 64'(m_axi_bready), 64'd0);
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_req_done", 64'(req_done), 64'd0);
        chk("rst_req_resp", 64'(req_resp), 64'd0);
        chk("rst_awaddr", 64'(m_axi_awaddr), 64'd0);
        chk("rst_awlen", 64'(m_axi_awlen), 64'd0);
        @(posedge ACLK); #1 ARESETN = 1'b1;

        // 1: single 8-beat burst, read back from slave memory
        expect_burst(0, 32'h0, 8'd7, 32'd1, 2'b00);
        drive_cmd(0, 32'h0, 8'd7, 32'd1, 8, 1'b0, 1'b0);
        wait_drain();
        for (int b = 0; b < 8; b++)
            chk($sformatf("mem_readback_%0d", b),
                64'(mem.exists(32'(4 * b)) ? mem[32'(4 * b)] : 32'hdead_beef), 64'(b + 1));

        // 2: all requesters valid, len=0 -> grants 0,1,2,3,0
        do_reset();
        expect_burst(0, 32'h000, 8'd0, 32'hA0, 2'b00);
        expect_burst(1, 32'h100, 8'd0, 32'hA1, 2'b00);
        expect_burst(2, 32'h200, 8'd0, 32'hA2, 2'b00);
        expect_burst(3, 32'h300, 8'd0, 32'hA3, 2'b00);
        expect_burst(0, 32'h400, 8'd0, 32'hB0, 2'b00);
        fork
            begin
                drive_cmd(0, 32'h000, 8'd0, 32'hA0, 1, 1'b0, 1'b1);
                drive_cmd(0, 32'h400, 8'd0, 32'hB0, 1, 1'b0, 1'b0);
            end
            drive_cmd(1, 32'h100, 8'd0, 32'hA1, 1, 1'b0, 1'b0);
            drive_cmd(2, 32'h200, 8'd0, 32'hA2, 1, 1'b0, 1'b0);
            drive_cmd(3, 32'h300, 8'd0, 32'hA3, 1, 1'b0, 1'b0);
        join
        wait_drain();

        // 3: 4KB crossing rejected locally; the burst ending exactly at 4KB is accepted
        expect_reject(2);
        drive_cmd(2, 32'hFF8, 8'd3, 32'd0, 0, 1'b0, 1'b0);
        wait_drain();
        expect_burst(2, 32'hFF0, 8'd3, 32'hC0, 2'b00);
        drive_cmd(2, 32'hFF0, 8'd3, 32'hC0, 4, 1'b0, 1'b0);
        wait_drain();

        // 4: slave and requester backpressure
        cfg_aw_delay = 5;
        cfg_w_rand   = 1'b1;
        expect_burst(3, 32'h2000, 8'd5, 32'hD0, 2'b00);
        drive_cmd(3, 32'h2000, 8'd5, 32'hD0, 6, 1'b1, 1'b0);
        wait_drain();
        cfg_aw_delay = 0;
        cfg_w_rand   = 1'b0;

        // 5: SLVERR passed through, next grant unaffected
        cfg_bresp = 2'b10;
        expect_burst(1, 32'h3000, 8'd1, 32'h30, 2'b10);
        drive_cmd(1, 32'h3000, 8'd1, 32'h30, 2, 1'b0, 1'b0);
        wait_drain();
        cfg_bresp = 2'b00;
        expect_burst(0, 32'h3100, 8'd0, 32'h31, 2'b00);
        drive_cmd(0, 32'h3100, 8'd0, 32'h31, 1, 1'b0, 1'b0);
        wait_drain();

        // 6: reset in the middle of W, then rr_ptr must restart at 0
        expect_burst(1, 32'h4000, 8'd7, 32'hE0, 2'b00);
        start = w_hs_cnt;
        fork
            drive_cmd(1, 32'h4000, 8'd7, 32'hE0, 8, 1'b0, 1'b0);
        join_none
        t = 0;
        while (w_hs_cnt < start + 2 && t < LIM) begin @(negedge ACLK); t++; end
        if (t >= LIM) unexp("mid_burst_timeout", 64'(w_hs_cnt));
        @(posedge ACLK); #3;
        ARESETN = 1'b0;
        #1;
        chk("rst_mid_awvalid", 64'(m_axi_awvalid), 64'd0);
        chk("rst_mid_wvalid", 64'(m_axi_wvalid), 64'd0);
        chk("rst_mid_bready", 64'(m_axi_bready), 64'd0);
        chk("rst_mid_req_wready", 64'(req_wready), 64'd0);
        abort = 1'b1;
        exp_grant.delete();
        exp_aw.delete();
        exp_w.delete();
        exp_done.delete();
        repeat (4) @(posedge ACLK);
        for (int i = 0; i < N; i++) begin
            v_valid[i]  = 1'b0;
            v_wvalid[i] = 1'b0;
        end
        abort = 1'b0;
        #1 ARESETN = 1'b1;
        expect_burst(1, 32'h5000, 8'd1, 32'hF0, 2'b00);
        expect_burst(3, 32'h5100, 8'd1, 32'hF8, 2'b00);
        @(posedge ACLK); #1;
        fork
            drive_cmd(1, 32'h5000, 8'd1, 32'hF0, 2, 1'b0, 1'b0);
            drive_cmd(3, 32'h5100, 8'd1, 32'hF8, 2, 1'b0, 1'b0);
        join
        wait_drain();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
